// File: rtl/axi_addr_arbiter_rr.sv
// N-master arbiter for one AXI address channel (AR or AW): round-robin or
// fixed-priority selection, one-hot master tag prepended to ID, grant locked until handshake.
module axi_addr_arbiter_rr #(
  parameter int NUM_M     = 3,
  parameter int ID_BITS   = 4,
  parameter int MID_BITS  = 4,
  parameter int ADDR_BITS = 32,
  parameter int LEN_BITS  = 4,
  parameter int SIZE_BITS = 3,
  parameter int ARB_MODE  = 0
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic [NUM_M*ID_BITS-1:0]      M_ID,
  input  logic [NUM_M*ADDR_BITS-1:0]    M_ADDR,
  input  logic [NUM_M*LEN_BITS-1:0]     M_LEN,
  input  logic [NUM_M*SIZE_BITS-1:0]    M_SIZE,
  input  logic [NUM_M*2-1:0]            M_BURST,
  input  logic [NUM_M-1:0]              M_VALID,
  output logic [NUM_M-1:0]              M_READY,
  output logic [MID_BITS+ID_BITS-1:0]   S_IDS,
  output logic [ADDR_BITS-1:0]          S_ADDR,
  output logic [LEN_BITS-1:0]           S_LEN,
  output logic [SIZE_BITS-1:0]          S_SIZE,
  output logic [1:0]                    S_BURST,
  output logic                          S_VALID,
  input  logic                          S_READY,
  output logic [NUM_M-1:0]              GRANT,
  output logic                          BUSY
);

  localparam int IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  if (NUM_M < 2 || NUM_M > MID_BITS) begin : g_param_err
    $error("axi_addr_arbiter_rr: NUM_M must be in 2..MID_BITS");
  end

  typedef enum logic {ST_IDLE, ST_LOCKED} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
  logic [IDX_W-1:0] win_idx, gnt_idx, gnt_nxt;
  logic             win_vld, gnt_act, hs;
  logic [MID_BITS-1:0] tag;

  // Winner search; RR scans offsets downward so the lowest offset from rr_ptr wins.
  always_comb begin
    int j;
    j       = 0;
    win_idx = '0;
    win_vld = 1'b0;
    if (ARB_MODE == 1) begin
      for (int i = 0; i < NUM_M; i++) begin
        if (M_VALID[i]) begin
          win_idx = IDX_W'(i);
          win_vld = 1'b1;
        end
      end
    end else begin
      for (int k = NUM_M - 1; k >= 0; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= NUM_M) j = j - NUM_M;
        if (M_VALID[j]) begin
          win_idx = IDX_W'(j);
          win_vld = 1'b1;
        end
      end
    end
  end

  assign gnt_act = (state_q == ST_LOCKED) || win_vld;
  assign gnt_idx = (state_q == ST_LOCKED) ? lock_idx_q : win_idx;
  assign gnt_nxt = (int'(gnt_idx) == NUM_M - 1) ? '0 : gnt_idx + 1'b1;
  assign hs      = S_VALID & S_READY;
  assign BUSY    = (state_q == ST_LOCKED);

  always_comb begin
    M_READY = '0;
    GRANT   = '0;
    S_IDS   = '0;
    S_ADDR  = '0;
    S_LEN   = '0;
    S_SIZE  = '0;
    S_BURST = '0;
    S_VALID = 1'b0;
    tag     = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (gnt_act && gnt_idx == IDX_W'(i)) begin
        tag        = MID_BITS'(1) << i;
        GRANT[i]   = 1'b1;
        S_VALID    = M_VALID[i];
        M_READY[i] = M_VALID[i] & S_READY;
        S_IDS      = {tag, M_ID[i*ID_BITS +: ID_BITS]};
        S_ADDR     = M_ADDR[i*ADDR_BITS +: ADDR_BITS];
        S_LEN      = M_LEN[i*LEN_BITS +: LEN_BITS];
        S_SIZE     = M_SIZE[i*SIZE_BITS +: SIZE_BITS];
        S_BURST    = M_BURST[i*2 +: 2];
      end
    end
  end

  // A locked master that drops VALID keeps the lock; only a handshake releases it.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_idx_d = lock_idx_q;
    if (hs) begin
      state_d  = ST_IDLE;
      rr_ptr_d = gnt_nxt;
    end else if (state_q == ST_IDLE && win_vld) begin
      state_d    = ST_LOCKED;
      lock_idx_d = win_idx;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      lock_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: tb/tb_axi_addr_arbiter_rr.sv
// Directed bench: a round-robin and a fixed-priority instance share one stimulus set.
module tb_axi_addr_arbiter_rr;
  logic        clk, rstn;
  logic [11:0] M_ID;
  logic [95:0] M_ADDR;
  logic [11:0] M_LEN;
  logic [8:0]  M_SIZE;
  logic [5:0]  M_BURST;
  logic [2:0]  M_VALID;
  logic        S_READY;

  logic [2:0]  rr_mrdy, fp_mrdy, rr_gnt, fp_gnt;
  logic [7:0]  rr_ids, fp_ids;
  logic [31:0] rr_addr, fp_addr;
  logic [3:0]  rr_len, fp_len;
  logic [2:0]  rr_size, fp_size;
  logic [1:0]  rr_burst, fp_burst;
  logic        rr_sv, fp_sv, rr_busy, fp_busy;

  int n_chk = 0;
  int n_pass = 0;

  axi_addr_arbiter_rr #(.ARB_MODE(0)) dut_rr (
    .clk(clk), .rstn(rstn), .M_ID(M_ID), .M_ADDR(M_ADDR), .M_LEN(M_LEN),
    .M_SIZE(M_SIZE), .M_BURST(M_BURST), .M_VALID(M_VALID), .M_READY(rr_mrdy),
    .S_IDS(rr_ids), .S_ADDR(rr_addr), .S_LEN(rr_len), .S_SIZE(rr_size),
    .S_BURST(rr_burst), .S_VALID(rr_sv), .S_READY(S_READY), .GRANT(rr_gnt),
    .BUSY(rr_busy));

  axi_addr_arbiter_rr #(.ARB_MODE(1)) dut_fp (
    .clk(clk), .rstn(rstn), .M_ID(M_ID), .M_ADDR(M_ADDR), .M_LEN(M_LEN),
    .M_SIZE(M_SIZE), .M_BURST(M_BURST), .M_VALID(M_VALID), .M_READY(fp_mrdy),
    .S_IDS(fp_ids), .S_ADDR(fp_addr), .S_LEN(fp_len), .S_SIZE(fp_size),
    .S_BURST(fp_burst), .S_VALID(fp_sv), .S_READY(S_READY), .GRANT(fp_gnt),
    .BUSY(fp_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive on the falling edge, look at combinational outputs 1ns later.
  task automatic drive(input logic [2:0] v, input logic rdy);
    @(negedge clk);
    M_VALID = v;
    S_READY = rdy;
    #1;
  endtask

  initial begin
    rstn    = 1'b0;
    M_ID    = {4'h7, 4'h6, 4'h5};
    M_ADDR  = {32'h0000_3000, 32'h0001_0040, 32'h0000_1000};
    M_LEN   = {4'hC, 4'h3, 4'h1};
    M_SIZE  = {3'h4, 3'h2, 3'h1};
    M_BURST = {2'b10, 2'b01, 2'b00};
    M_VALID = '0;
    S_READY = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", rr_gnt, 3'b000);
    chk("rst_svalid", rr_sv, 1'b0);
    chk("rst_busy", rr_busy, 1'b0);
    chk("rst_ids", rr_ids, 8'h00);
    chk("rst_addr", rr_addr, 32'h0);
    chk("rst_mready", rr_mrdy, 3'b000);
    @(negedge clk);
    rstn = 1'b1;

    // RR fairness with everyone requesting
    drive(3'b111, 1'b1); chk("rr_g0", rr_gnt, 3'b001); chk("rr_ids0", rr_ids, 8'h15);
    drive(3'b111, 1'b1); chk("rr_g1", rr_gnt, 3'b010); chk("rr_ids1", rr_ids, 8'h26);
    drive(3'b111, 1'b1); chk("rr_g2", rr_gnt, 3'b100); chk("rr_ids2", rr_ids, 8'h47);
    drive(3'b111, 1'b1); chk("rr_g3", rr_gnt, 3'b001); chk("rr_mrdy3", rr_mrdy, 3'b001);
    // rr_ptr = 1 now

    // Lock on M0 while M2 also asks
    drive(3'b001, 1'b0); chk("lk_g0", rr_gnt, 3'b001); chk("lk_busy0", rr_busy, 1'b0);
    chk("lk_mrdy0", rr_mrdy, 3'b000);
    drive(3'b101, 1'b0); chk("lk_g1", rr_gnt, 3'b001); chk("lk_busy1", rr_busy, 1'b1);
    chk("lk_ids1", rr_ids, 8'h15);
    drive(3'b101, 1'b0); chk("lk_g2", rr_gnt, 3'b001); chk("lk_busy2", rr_busy, 1'b1);
    drive(3'b101, 1'b1); chk("lk_g3", rr_gnt, 3'b001); chk("lk_mrdy3", rr_mrdy, 3'b001);
    drive(3'b100, 1'b1); chk("lk_g4", rr_gnt, 3'b100); chk("lk_ids4", rr_ids, 8'h47);
    chk("lk_busy4", rr_busy, 1'b0);
    // rr_ptr = 0 now

    // Zero-latency pass-through of M1
    drive(3'b010, 1'b1);
    chk("zl_sv", rr_sv, 1'b1);
    chk("zl_addr", rr_addr, 32'h0001_0040);
    chk("zl_mrdy", rr_mrdy, 3'b010);
    chk("zl_busy", rr_busy, 1'b0);
    chk("zl_len", rr_len, 4'h3);
    chk("zl_size", rr_size, 3'h2);
    chk("zl_burst", rr_burst, 2'b01);
    chk("zl_ids", rr_ids, 8'h26);
    // rr_ptr = 2 now

    // Idle for 10 cycles leaves rr_ptr alone
    for (int c = 0; c < 10; c++) begin
      drive(3'b000, 1'b1);
      chk("idle_gnt", rr_gnt, 3'b000);
      chk("idle_sv", rr_sv, 1'b0);
    end
    chk("idle_addr", rr_addr, 32'h0);
    chk("idle_ids", rr_ids, 8'h00);
    drive(3'b111, 1'b1); chk("idle_next", rr_gnt, 3'b100);
    // rr_ptr = 0 now

    // Violation then mid-lock reset
    drive(3'b001, 1'b1); chk("vr_pre", rr_gnt, 3'b001);  // rr_ptr -> 1
    drive(3'b010, 1'b0); chk("vr_g0", rr_gnt, 3'b010);
    drive(3'b000, 1'b0);
    chk("vr_sv", rr_sv, 1'b0);
    chk("vr_gnt", rr_gnt, 3'b010);
    chk("vr_busy", rr_busy, 1'b1);
    chk("vr_mrdy", rr_mrdy, 3'b000);
    drive(3'b000, 1'b1);
    chk("vr_hold", rr_gnt, 3'b010);
    #2 rstn = 1'b0;
    #1;
    chk("mr_gnt", rr_gnt, 3'b000);
    chk("mr_busy", rr_busy, 1'b0);
    chk("mr_sv", rr_sv, 1'b0);
    chk("mr_ids", rr_ids, 8'h00);
    @(negedge clk);
    rstn = 1'b1;
    drive(3'b111, 1'b1); chk("mr_first", rr_gnt, 3'b001);

    // Fixed priority: M2 always beats M0
    for (int c = 0; c < 4; c++) begin
      drive(3'b101, 1'b1);
      chk("fp_gnt", fp_gnt, 3'b100);
      chk("fp_ids", fp_ids, 8'h47);
      chk("fp_mrdy", fp_mrdy, 3'b100);
    end
    drive(3'b001, 1'b1); chk("fp_solo", fp_gnt, 3'b001);

    drive(3'b000, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_addr_arbiter_rr.md
Name: axi_addr_arbiter_rr

Overview:
Parametrised N-master arbiter for one AXI address channel (AR or AW). It sits in the bus interconnect in front of the slave decoder. It selects one master by round-robin or fixed priority, forwards that master's address payload with a one-hot master tag prepended to the ID, and locks the grant until the slave handshake completes. Each interconnect instantiates it twice: once for read and once for write.

Parameters:
NUM_M, 3, number of masters (2..MID_BITS)
ID_BITS, 4, master-side ID width
MID_BITS, 4, width of the one-hot master tag prepended to the ID
ADDR_BITS, 32, address width
LEN_BITS, 4, burst length width
SIZE_BITS, 3, burst size width
ARB_MODE, 0, 0 = round-robin, 1 = fixed priority (highest index wins)

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
M_ID  in  NUM_M*ID_BITS  per-master ID, master i in slice [i*ID_BITS +: ID_BITS]; all M_* vectors use the same slicing
M_ADDR  in  NUM_M*ADDR_BITS  per-master address
M_LEN  in  NUM_M*LEN_BITS  per-master burst length
M_SIZE  in  NUM_M*SIZE_BITS  per-master burst size
M_BURST  in  NUM_M*2  per-master burst type
M_VALID  in  NUM_M  per-master valid
M_READY  out  NUM_M  per-master ready
S_IDS  out  MID_BITS+ID_BITS  {one-hot master tag, ID}
S_ADDR  out  ADDR_BITS  forwarded address
S_LEN  out  LEN_BITS  forwarded length
S_SIZE  out  SIZE_BITS  forwarded size
S_BURST  out  2  forwarded burst type
S_VALID  out  1  forwarded valid
S_READY  in  1  slave ready
GRANT  out  NUM_M  one-hot current grant (0 when idle)
BUSY  out  1  high while a grant is locked

Behaviour:
- Reset (rstn low, asynchronous): state IDLE; rr_ptr = 0; lock_idx = 0. With all M_VALID low, every output is 0.
- State machine, IDLE and LOCKED:
  - IDLE: the winner is chosen combinationally in the same cycle (zero latency) from M_VALID. S_* is driven from the winner.
    - If S_READY=1 in that cycle, the handshake completes and the state stays IDLE.
    - If S_READY=0, go to LOCKED with lock_idx = winner.
  - LOCKED: GRANT is fixed at lock_idx regardless of other M_VALID bits. On S_VALID && S_READY, return to IDLE.
- Round-robin (ARB_MODE=0): search starts at rr_ptr and wraps modulo NUM_M. The first asserted M_VALID wins.
  - After every completed handshake, rr_ptr = (winner+1) mod NUM_M.
  - rr_ptr is unchanged while idle with no requests.
- Fixed priority (ARB_MODE=1): the highest asserted index wins. rr_ptr is ignored.
- Forwarding:
  - S_VALID = M_VALID[granted].
  - M_READY[granted] = M_VALID[granted] & S_READY; all other M_READY bits are 0.
  - S_IDS tag has bit g set (g = granted index) and all other bits 0. The low ID_BITS of S_IDS are M_ID of g.
- No grant (IDLE, no valid): S_* = 0, GRANT = 0, BUSY = 0.
- BUSY = (state == LOCKED).
- Simultaneous events:
  - A new request arriving in the same cycle as a handshake is arbitrated next cycle using the updated rr_ptr.
  - A non-granted master's VALID has no effect while LOCKED.
- Protocol violation: if the locked master drops VALID before the handshake, the lock is held. S_VALID follows (goes 0). The lock releases only on a handshake.
- Mid-operation reset: returns to IDLE immediately and rr_ptr = 0. No handshake is reported.
- Elaboration error if NUM_M > MID_BITS or NUM_M < 2.

Test Plan:
1. RR fairness: NUM_M=3, all M_VALID held high, S_READY=1 -> GRANT sequence 001, 010, 100, 001 on consecutive cycles; S_IDS tags 0001, 0010, 0100.
2. Lock: M0 valid with S_READY=0 for 3 cycles, M2 valid from cycle 1 -> GRANT stays 001 and BUSY=1 until S_READY=1. Handshake on M0. M2 granted the next cycle with S_IDS = {0100, M_ID[2]}.
3. Zero latency: idle, M1 valid with ADDR=0x0001_0040 and S_READY=1 -> same cycle S_VALID=1, S_ADDR=0x0001_0040, M_READY=010, BUSY stays 0.
4. Fixed priority (ARB_MODE=1): M0 and M2 continuously valid, S_READY=1 -> M2 granted every cycle; M0 is never granted.
5. Violation and reset: locked on M1, M1 drops VALID -> S_VALID=0 and GRANT stays 010. Assert rstn low mid-lock -> all outputs 0 and rr_ptr=0; after release, all-valid request grants M0 first.
6. Idle: no M_VALID for 10 cycles -> all S_* = 0, GRANT = 0, and rr_ptr is unchanged (verified by the next grant order).
